// File: rtl/mux_scan_controller_pkg.sv
// Shared types and constants for the 7-to-1 mux scan controller.
// Also provides the scan latency helper used by anything that needs to predict done timing.
package mux_scan_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } scan_state_e;

   localparam int NUM_LANES_DEFAULT     = 7;
   localparam int SEL_W_DEFAULT         = 3;
   localparam int SETTLE_CYCLES_DEFAULT = 1;
   localparam int CNT_W                 = 4;

   // Edges from the start-accepting edge (edge 0) to the edge after which done is high.
   function automatic int scan_latency(input int num_lanes, input int settle_cycles);
      return num_lanes * (settle_cycles + 1) + 1;
   endfunction

   localparam int SCAN_LATENCY_DEFAULT = scan_latency(NUM_LANES_DEFAULT, SETTLE_CYCLES_DEFAULT);

endpackage

// File: rtl/mux_scan_controller_if.sv
// Scan request/result bundle between a requester and the mux scan controller.
// The controller side uses the slave modport; the requester/mux side uses master.
interface mux_scan_controller_if #(
   parameter int NUM_LANES = mux_scan_controller_pkg::NUM_LANES_DEFAULT,
   parameter int SEL_W     = mux_scan_controller_pkg::SEL_W_DEFAULT
);
   logic                 start;
   logic [NUM_LANES-1:0] din;
   logic                 y_in;
   logic [NUM_LANES-1:0] lane;
   logic [SEL_W-1:0]     sel;
   logic                 busy;
   logic                 done;
   logic [NUM_LANES-1:0] dout;
   logic                 mismatch;

   modport slave (
      input  start, din, y_in,
      output lane, sel, busy, done, dout, mismatch
   );

   modport master (
      output start, din, y_in,
      input  lane, sel, busy, done, dout, mismatch
   );
endinterface

// File: rtl/scan_settle_timer.sv
// Settle interval timer: loads SETTLE_CYCLES-1, counts down to zero and holds there.
// zero_o tells the scan FSM that the select has been stable long enough to sample y.
module scan_settle_timer
   import mux_scan_controller_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_controller.sv
// Steps the mux select over every lane, samples y after a settle interval and rebuilds the word.
// Any lane whose sampled y differs from the driven data sets the sticky mismatch flag.
//
// state  | meaning
// IDLE   | sel parked at 0, waiting for start
// SETTLE | select held while the mux output settles
// SAMPLE | y captured into dout[sel] and compared with lane[sel]
// DONE   | scan finished, done pulse issued on the next cycle
module mux_scan_controller
   import mux_scan_controller_pkg::*;
#(
   parameter int NUM_LANES     = NUM_LANES_DEFAULT,
   parameter int SEL_W         = SEL_W_DEFAULT,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux_scan_controller_if.slave  scan_if
);

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_LANES - 1);

   scan_state_e          state_q;
   scan_state_e          state_d;
   logic [SEL_W-1:0]     sel_q;
   logic [SEL_W-1:0]     sel_d;
   logic [NUM_LANES-1:0] lane_q;
   logic [NUM_LANES-1:0] lane_d;
   logic [NUM_LANES-1:0] dout_q;
   logic [NUM_LANES-1:0] dout_d;
   logic                 busy_q;
   logic                 busy_d;
   logic                 done_q;
   logic                 done_d;
   logic                 mismatch_q;
   logic                 mismatch_d;

   logic                 tmr_load;
   logic                 tmr_dec;
   logic                 tmr_zero;

   scan_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (tmr_load),
      .dec_i  (tmr_dec),
      .zero_o (tmr_zero)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      lane_d     = lane_q;
      dout_d     = dout_q;
      mismatch_d = mismatch_q;
      done_d     = 1'b0;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            sel_d = '0;
            if (scan_if.start) begin
               lane_d     = scan_if.din;
               dout_d     = '0;
               mismatch_d = 1'b0;
               tmr_load   = 1'b1;
               state_d    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (tmr_zero) begin
               state_d = ST_SAMPLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_SAMPLE: begin
            dout_d[sel_q] = scan_if.y_in;
            if (scan_if.y_in != lane_q[sel_q]) begin
               mismatch_d = 1'b1;
            end
            if (sel_q == LAST_SEL) begin
               state_d = ST_DONE;
            end else begin
               sel_d    = sel_q + SEL_W'(1);
               tmr_load = 1'b1;
               state_d  = ST_SETTLE;
            end
         end
         ST_DONE: begin
            // start is deliberately not looked at here; the scan always rests one cycle in IDLE
            done_d  = 1'b1;
            sel_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         lane_q     <= '0;
         dout_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         lane_q     <= lane_d;
         dout_q     <= dout_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign scan_if.lane     = lane_q;
   assign scan_if.sel      = sel_q;
   assign scan_if.busy     = busy_q;
   assign scan_if.done     = done_q;
   assign scan_if.dout     = dout_q;
   assign scan_if.mismatch = mismatch_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller: two instances (settle 1 and settle 3) fed by a behavioural MyMux.
// A cycle-indexed scan model predicts every output; directed scans pin latency and captured words.
`timescale 1ns/1ps
module tb_mux_scan_controller;
   import mux_scan_controller_pkg::*;

   localparam int N   = 7;
   localparam int S_A = 1;
   localparam int S_B = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic fault_a = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mux_scan_controller_if #(.NUM_LANES(N), .SEL_W(3)) if_a ();
   mux_scan_controller_if #(.NUM_LANES(N), .SEL_W(3)) if_b ();

   // behavioural MyMux; fault_a models a mux output stuck at 0
   assign if_a.y_in = fault_a ? 1'b0 : if_a.lane[if_a.sel];
   assign if_b.y_in = if_b.lane[if_b.sel];

   mux_scan_controller #(.NUM_LANES(N), .SEL_W(3), .SETTLE_CYCLES(S_A)) u_dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .scan_if (if_a.slave)
   );

   mux_scan_controller #(.NUM_LANES(N), .SEL_W(3), .SETTLE_CYCLES(S_B)) u_dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .scan_if (if_b.slave)
   );

   // model: e = edges since the start-accepting edge; lane k is held for (s+1) cycles
   bit           m_act  [2];
   int           m_e    [2];
   logic [N-1:0] m_w    [2];
   logic [N-1:0] m_dout [2];
   bit           m_mis  [2];

   function automatic int settle_of(input int i);
      return (i == 0) ? S_A : S_B;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i]  = 1'b0;
         m_e[i]    = 0;
         m_w[i]    = '0;
         m_dout[i] = '0;
         m_mis[i]  = 1'b0;
      end
   endtask

   task automatic model_step(input int i, input logic start, input logic [N-1:0] din, input logic fault);
      int   s;
      int   t;
      int   k;
      logic y;
      s = settle_of(i);
      t = N * (s + 1);
      if (start && (!m_act[i] || m_e[i] == t + 1)) begin
         m_act[i]  = 1'b1;
         m_e[i]    = 0;
         m_w[i]    = din;
         m_dout[i] = '0;
         m_mis[i]  = 1'b0;
      end else if (m_act[i]) begin
         m_e[i]++;
         if ((m_e[i] % (s + 1) == 0) && (m_e[i] <= t)) begin
            k = m_e[i] / (s + 1) - 1;
            y = fault ? 1'b0 : m_w[i][k];
            m_dout[i][k] = y;
            if (y != m_w[i][k]) m_mis[i] = 1'b1;
         end
         if (m_e[i] > t + 1) m_act[i] = 1'b0;
      end
   endtask

   task automatic chk_inst(input int i, input logic busy, input logic done, input logic [2:0] sel,
                           input logic [N-1:0] lane, input logic [N-1:0] dout, input logic mis);
      int s;
      int t;
      int e_sel;
      s = settle_of(i);
      t = N * (s + 1);
      if (!m_act[i])      e_sel = 0;
      else if (m_e[i] < t) e_sel = m_e[i] / (s + 1);
      else if (m_e[i] == t) e_sel = N - 1;
      else                 e_sel = 0;
      chk($sformatf("busy_%0d", i), busy, (m_act[i] && m_e[i] < t) ? 1 : 0);
      chk($sformatf("done_%0d", i), done, (m_act[i] && m_e[i] == t + 1) ? 1 : 0);
      chk($sformatf("sel_%0d", i), sel, e_sel);
      chk($sformatf("sel_range_%0d", i), (sel <= 3'd6) ? 1 : 0, 1);
      chk($sformatf("lane_%0d", i), lane, m_w[i]);
      chk($sformatf("dout_%0d", i), dout, m_dout[i]);
      chk($sformatf("mismatch_%0d", i), mis, m_mis[i] ? 1 : 0);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         model_step(0, if_a.start, if_a.din, fault_a);
         model_step(1, if_b.start, if_b.din, 1'b0);
      end
      #1;
      chk_inst(0, if_a.busy, if_a.done, if_a.sel, if_a.lane, if_a.dout, if_a.mismatch);
      chk_inst(1, if_b.busy, if_b.done, if_b.sel, if_b.lane, if_b.dout, if_b.mismatch);
   end

   function automatic logic done_of(input int i);
      return (i == 0) ? if_a.done : if_b.done;
   endfunction

   task automatic drive(input int i, input logic start, input logic [N-1:0] din);
      if (i == 0) begin
         if_a.start = start;
         if_a.din   = din;
      end else begin
         if_b.start = start;
         if_b.din   = din;
      end
   endtask

   // one scan; abuse=1 toggles din every cycle, pokes start mid-scan and in the DONE cycle
   task automatic scan(input int i, input logic [N-1:0] w, input bit abuse, output int lat);
      logic [N-1:0] d;
      d = w;
      @(negedge clk);
      drive(i, 1'b1, d);
      @(negedge clk);
      drive(i, 1'b0, d);
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (abuse) begin
            d = ~d;
            drive(i, (n == 5 || n == 14) ? 1'b1 : 1'b0, d);
         end
         if (done_of(i)) begin
            lat = n;
            break;
         end
      end
      drive(i, 1'b0, d);
   endtask

   initial begin
      int lat;
      int t_done [3];
      int nd;

      if_a.start = 1'b0;
      if_a.din   = '0;
      if_b.start = 1'b0;
      if_b.din   = '0;

      repeat (3) @(negedge clk);
      chk("reset_sel", if_a.sel, 0);
      chk("reset_busy", if_a.busy, 0);
      chk("reset_done", if_a.done, 0);
      chk("reset_dout", if_a.dout, 0);
      chk("reset_lane", if_a.lane, 0);
      rst_n = 1'b1;
      @(negedge clk);

      scan(0, 7'b0101010, 1'b0, lat);
      chk("golden_latency", lat, 15);
      chk("golden_latency_pkg", lat, SCAN_LATENCY_DEFAULT);
      chk("golden_dout", if_a.dout, 7'b0101010);
      chk("golden_mismatch", if_a.mismatch, 0);

      fault_a = 1'b1;
      scan(0, 7'b1111111, 1'b0, lat);
      chk("fault_latency", lat, 15);
      chk("fault_dout", if_a.dout, 7'b0000000);
      chk("fault_mismatch", if_a.mismatch, 1);
      chk("fault_lane", if_a.lane, 7'b1111111);
      fault_a = 1'b0;

      scan(1, 7'b1000001, 1'b0, lat);
      chk("settle3_latency", lat, 29);
      chk("settle3_dout", if_b.dout, 7'b1000001);
      chk("settle3_mismatch", if_b.mismatch, 0);

      scan(0, 7'b0110011, 1'b1, lat);
      chk("abuse_latency", lat, 15);
      chk("abuse_dout", if_a.dout, 7'b0110011);
      chk("abuse_lane", if_a.lane, 7'b0110011);
      chk("abuse_mismatch", if_a.mismatch, 0);

      // reset in the middle of a scan after three lanes were captured
      @(negedge clk);
      drive(0, 1'b1, 7'b1100110);
      @(negedge clk);
      drive(0, 1'b0, 7'b1100110);
      repeat (6) @(negedge clk);
      chk("pre_reset_dout", if_a.dout, 7'b0000110);
      rst_n = 1'b0;
      #1;
      chk("midrst_sel", if_a.sel, 0);
      chk("midrst_busy", if_a.busy, 0);
      chk("midrst_dout", if_a.dout, 0);
      chk("midrst_mismatch", if_a.mismatch, 0);
      @(negedge clk);
      rst_n = 1'b1;
      scan(0, 7'b1100110, 1'b0, lat);
      chk("after_reset_latency", lat, 15);
      chk("after_reset_dout", if_a.dout, 7'b1100110);

      // start held high: back-to-back scans with one IDLE cycle between them
      @(negedge clk);
      drive(0, 1'b1, 7'b0011100);
      nd = 0;
      for (int n = 0; n < 80 && nd < 3; n++) begin
         @(negedge clk);
         if (if_a.done) begin
            t_done[nd] = n;
            nd++;
         end
      end
      drive(0, 1'b0, 7'b0011100);
      chk("hold_done_count", nd, 3);
      if (nd == 3) begin
         chk("hold_spacing_1", t_done[1] - t_done[0], 16);
         chk("hold_spacing_2", t_done[2] - t_done[1], SCAN_LATENCY_DEFAULT + 1);
      end
      chk("hold_dout", if_a.dout, 7'b0011100);

      repeat (20) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
Sequencing stage wrapped around the 7-to-1 mux (MyMux). It drives the mux data lanes (i0..i6) and the 3-bit select (s), and consumes the mux output (y). On a start request it latches a 7-bit word and steps the select through lanes 0..6. For each lane it waits a settle interval, then samples y. It rebuilds the word, flags any lane where y disagrees with the driven data, and gives a self-checking scan of the mux for the lab datapath.

Parameters:
NUM_LANES, 7, number of mux data inputs scanned; fixed at 7 for MyMux.
SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_LANES.
SETTLE_CYCLES, 1, cycles the select is held before y is sampled; legal range 1..15.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  scan request; sampled only in IDLE.
din  input  NUM_LANES  word to scan; latched when start is accepted.
y_in  input  1  mux output y.
lane  output  NUM_LANES  registered copy of din; lane[k] drives mux input ik.
sel  output  SEL_W  mux select s.
busy  output  1  high from the cycle after start is accepted through the last SAMPLE cycle.
done  output  1  single-cycle pulse when the scan is complete.
dout  output  NUM_LANES  captured word; dout[k] is y sampled while sel==k.
mismatch  output  1  sticky per scan; set if any sampled y differs from lane[sel].

Behaviour:
- Reset (async assert, sync-released use on the next clk): state=IDLE; sel, lane, dout = 0; busy, done, mismatch = 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - sel=0.
  - start=1: lane<=din, dout<=0, mismatch<=0, cnt<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: hold sel. If cnt==0 go to SAMPLE, else decrement cnt.
- SAMPLE (exactly 1 cycle):
  - dout[sel]<=y_in.
  - If y_in != lane[sel], mismatch<=1.
  - If sel==NUM_LANES-1, go to DONE.
  - Otherwise sel<=sel+1, cnt<=SETTLE_CYCLES-1, go to SETTLE.
- DONE: done=1 for one cycle; sel<=0; go to IDLE. A start seen in DONE is ignored.
- Latency: counting the edge that accepts start as edge 0, done is high after edge NUM_LANES*(SETTLE_CYCLES+1)+1. That is 15 cycles for the defaults.
- Throughput: back-to-back scans are separated by one IDLE cycle.
- sel never takes values >= NUM_LANES; 3'b111 is never driven.
- start while busy or in DONE: ignored, with no side effects.
- din changes mid-scan: no effect, because lane holds the latched value.
- dout, mismatch and lane hold their values after DONE until the next accepted start.
- rst_n asserted mid-scan: immediate return to reset values; the partial dout is discarded.
- y_in is sampled only in SAMPLE and is ignored in all other states.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - NUM_LANES_DEFAULT=7 and SEL_W_DEFAULT=3;
  - a helper constant for the scan latency formula, used by the bench.
- One sub-module, scan_settle_timer: a load/decrement counter with a zero flag, parameterised by SETTLE_CYCLES.
- MyMux is instantiated by the parent, not inside this block.

Test Plan:
- Golden scan: defaults, din=7'b0101010, y_in fed by MyMux → sel steps 0..6 with each value held for 2 cycles; done after edge 15; dout=7'b0101010; mismatch=0.
- Faulty mux: y_in tied 0, din=7'b1111111 → dout=7'b0000000; mismatch=1 from lane 0's SAMPLE onward; done still after edge 15.
- Settle sweep: SETTLE_CYCLES=3, din=7'b1000001 → done after edge 29; dout=7'b1000001; each sel held 4 cycles.
- Reset mid-scan: assert rst_n=0 at cycle 6 → sel=0, busy=0, dout=0, mismatch=0 immediately; a new start then completes normally.
- Start hold/abuse:
  - start held high continuously → repeated scans; done pulses spaced 16 cycles apart.
  - din toggled mid-scan → no effect on the current scan.
- Select range: across all of the above, assert sel<=6 on every cycle and sel==0 whenever in IDLE.
